// File: rtl/scoreboard_issue_ctrl.sv
// Decode-stage hazard/issue controller: per-register pending-write counters, CC counter,
// multi-port retire and a branch-wait FSM. Define SCB_WB_BYPASS_EN to let sources see same-cycle retires.
module scoreboard_issue_ctrl #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int NUM_WB   = 2,
    parameter int CNT_W    = 2
) (
    input  logic                    I_CLOCK,
    input  logic                    I_RESET,
    input  logic                    I_Valid,
    input  logic [IDX_W-1:0]        I_Src1Idx,
    input  logic                    I_Src1Use,
    input  logic [IDX_W-1:0]        I_Src2Idx,
    input  logic                    I_Src2Use,
    input  logic [IDX_W-1:0]        I_DestIdx,
    input  logic                    I_DestWrite,
    input  logic                    I_CCRead,
    input  logic                    I_CCWrite,
    input  logic                    I_IsBranch,
    input  logic [NUM_WB-1:0]       I_WBEn,
    input  logic [NUM_WB*IDX_W-1:0] I_WBIdx,
    input  logic                    I_WBCCEn,
    input  logic                    I_BranchResolve,
    output logic                    O_Issue,
    output logic                    O_DepStall,
    output logic                    O_BranchStall,
    output logic [NUM_REGS-1:0]     O_Busy,
    output logic                    O_CCBusy,
    output logic                    O_Error,
    output logic                    O_DbgState
);

    localparam int DW = $clog2(NUM_WB + 1);
    localparam int SW = ((CNT_W > DW) ? CNT_W : DW) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {RUN = 1'b0, BR_WAIT = 1'b1} state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q [NUM_REGS];
    logic [CNT_W-1:0]     cnt_d [NUM_REGS];
    logic [CNT_W-1:0]     cc_cnt_q, cc_cnt_d;
    logic                 error_q, error_d;
    logic [DW-1:0]        dec_cnt [NUM_REGS];
    logic [NUM_REGS-1:0]  busy, full, src_busy;
    logic                 cc_busy, dep_stall, issue;

    function automatic logic sel_bit(input logic [NUM_REGS-1:0] v, input logic [IDX_W-1:0] idx);
        logic res;
        res = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (idx == IDX_W'(r)) res = v[r];
        end
        return res;
    endfunction

    // Out-of-range retire indices never match a tracked register, so they are dropped here.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            dec_cnt[r] = '0;
            for (int p = 0; p < NUM_WB; p++) begin
                if (I_WBEn[p] && (I_WBIdx[p*IDX_W +: IDX_W] == IDX_W'(r)))
                    dec_cnt[r] = dec_cnt[r] + DW'(1);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
            full[r] = (cnt_q[r] == CNT_MAX);
        end
    end

`ifdef SCB_WB_BYPASS_EN
    // A source is free once every outstanding write to it retires this cycle.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            src_busy[r] = (SW'(cnt_q[r]) > SW'(dec_cnt[r]));
    end
`else
    assign src_busy = busy;
`endif

    assign cc_busy   = (cc_cnt_q != '0);
    assign dep_stall = I_Valid & ((I_Src1Use & sel_bit(src_busy, I_Src1Idx)) |
                                  (I_Src2Use & sel_bit(src_busy, I_Src2Idx)) |
                                  (I_CCRead & cc_busy) |
                                  (I_DestWrite & sel_bit(full, I_DestIdx)) |
                                  (I_CCWrite & (cc_cnt_q == CNT_MAX)));
    assign issue     = I_Valid & ~dep_stall & (state_q == RUN);

    // Increment happens before the retire subtraction so issue+retire on one register nets out.
    always_comb begin
        logic [SW-1:0] sum;
        logic          inc;
        error_d = error_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc = issue & I_DestWrite & (I_DestIdx == IDX_W'(r));
            sum = SW'(cnt_q[r]) + SW'(inc);
            if (sum < SW'(dec_cnt[r])) begin
                cnt_d[r] = '0;
                error_d  = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum - SW'(dec_cnt[r]));
            end
        end
        sum = SW'(cc_cnt_q) + SW'(issue & I_CCWrite);
        if (sum < SW'(I_WBCCEn)) begin
            cc_cnt_d = '0;
            error_d  = 1'b1;
        end else begin
            cc_cnt_d = CNT_W'(sum - SW'(I_WBCCEn));
        end
    end

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            cc_cnt_q <= '0;
            error_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            cc_cnt_q <= cc_cnt_d;
            error_q  <= error_d;
        end
    end

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN:     if (issue && I_IsBranch) state_q <= BR_WAIT;
                BR_WAIT: if (I_BranchResolve) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign O_Issue       = issue;
    assign O_DepStall    = dep_stall;
    assign O_BranchStall = (state_q == BR_WAIT) | (I_Valid & I_IsBranch & ~issue);
    assign O_Busy        = busy;
    assign O_CCBusy      = cc_busy;
    assign O_Error       = error_q;
    assign O_DbgState    = state_q;

endmodule
